// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the fetch stage: fetch FSM state encoding and
// the machine word width used by instruction memory and decode.
package instruction_fetch_unit_pkg;

  localparam int WORD_W = 32;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_HALT  = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

endpackage

// File: rtl/instruction_fetch_unit.sv
// Program counter and fetch stage. The PC is a signed word index that drives
// the instruction memory's asynchronous address. The returned word is captured
// into an instruction register with a valid flag. Halt and out-of-range fetches
// park the FSM in a sticky state until reset.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic signed [WORD_W-1:0] RESET_PC   = 32'sd0,
  parameter int                       IMEM_DEPTH = 5,
  parameter int                       CNT_WIDTH  = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     stall,
  input  logic                     branch_taken,
  input  logic signed [WORD_W-1:0] branch_target,
  input  logic                     jump,
  input  logic signed [WORD_W-1:0] jump_target,
  input  logic                     halt_req,
  output logic signed [WORD_W-1:0] imem_addr,
  input  logic        [WORD_W-1:0] imem_rd,
  output logic        [WORD_W-1:0] instr,
  output logic signed [WORD_W-1:0] instr_pc,
  output logic                     instr_valid,
  output logic signed [WORD_W-1:0] pc_plus1,
  output logic     [CNT_WIDTH-1:0] fetch_count,
  output logic                     halted,
  output logic                     fetch_fault
);

  localparam logic signed [WORD_W-1:0] DEPTH_S = WORD_W'(IMEM_DEPTH);

  logic        [1:0]           state_r,    state_nxt_s;
  logic signed [WORD_W-1:0]    pc_r,       pc_nxt_s;
  logic        [WORD_W-1:0]    instr_r,    instr_nxt_s;
  logic signed [WORD_W-1:0]    instr_pc_r, instr_pc_nxt_s;
  logic                        valid_r,    valid_nxt_s;
  logic        [CNT_WIDTH-1:0] count_r,    count_nxt_s;
  logic                        pc_in_range_s;
  logic signed [WORD_W-1:0]    pc_plus1_s;

  assign pc_in_range_s = (pc_r >= 32'sd0) && (pc_r < DEPTH_S);
  assign pc_plus1_s    = pc_r + 32'sd1;

  // State register: every piece of fetch state, with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r    <= ST_RUN;
      pc_r       <= RESET_PC;
      instr_r    <= 32'd0;
      instr_pc_r <= 32'sd0;
      valid_r    <= 1'b0;
      count_r    <= CNT_WIDTH'(0);
    end else begin
      state_r    <= state_nxt_s;
      pc_r       <= pc_nxt_s;
      instr_r    <= instr_nxt_s;
      instr_pc_r <= instr_pc_nxt_s;
      valid_r    <= valid_nxt_s;
      count_r    <= count_nxt_s;
    end
  end

  // Next-state and next-PC priority mux: halt > jump > branch > stall > sequential.
  always_comb begin
    state_nxt_s    = state_r;
    pc_nxt_s       = pc_r;
    instr_nxt_s    = instr_r;
    instr_pc_nxt_s = instr_pc_r;
    valid_nxt_s    = 1'b0;
    count_nxt_s    = count_r;
    case (state_r)
      ST_RUN: begin
        if (halt_req) begin
          state_nxt_s = ST_HALT;
        end else if (jump) begin
          pc_nxt_s = jump_target;
        end else if (branch_taken) begin
          pc_nxt_s = branch_target;
        end else if (stall) begin
          valid_nxt_s = valid_r;
        end else if (pc_in_range_s) begin
          instr_nxt_s    = imem_rd;
          instr_pc_nxt_s = pc_r;
          valid_nxt_s    = 1'b1;
          pc_nxt_s       = pc_plus1_s;
          count_nxt_s    = count_r + CNT_WIDTH'(1);
        end else begin
          // Sequential fetch from an out-of-range PC: stop before using it.
          state_nxt_s = ST_FAULT;
        end
      end
      ST_HALT: begin
        state_nxt_s = ST_HALT;
      end
      ST_FAULT: begin
        state_nxt_s = ST_FAULT;
      end
      default: begin
        // Unused encoding is treated as a fault so fetching stops safely.
        state_nxt_s = ST_FAULT;
      end
    endcase
  end

  // Output decode; the memory address is clamped to 0 whenever the PC is out of range.
  always_comb begin
    imem_addr   = 32'sd0;
    if (pc_in_range_s) begin
      imem_addr = pc_r;
    end else begin
      imem_addr = 32'sd0;
    end
    instr       = instr_r;
    instr_pc    = instr_pc_r;
    instr_valid = valid_r;
    pc_plus1    = pc_plus1_s;
    fetch_count = count_r;
    halted      = (state_r == ST_HALT);
    fetch_fault = (state_r == ST_FAULT);
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed self-checking bench for instruction_fetch_unit against a
// five-word memory holding 0xA0..0xA4.
module tb_instruction_fetch_unit;

  logic               clk;
  logic               reset_n;
  logic               stall;
  logic               branch_taken;
  logic signed [31:0] branch_target;
  logic               jump;
  logic signed [31:0] jump_target;
  logic               halt_req;
  logic signed [31:0] imem_addr;
  logic        [31:0] imem_rd;
  logic        [31:0] instr;
  logic signed [31:0] instr_pc;
  logic               instr_valid;
  logic signed [31:0] pc_plus1;
  logic        [31:0] fetch_count;
  logic               halted;
  logic               fetch_fault;

  int tests_run;
  int tests_failed;

  instruction_fetch_unit dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .halt_req      (halt_req),
    .imem_addr     (imem_addr),
    .imem_rd       (imem_rd),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .pc_plus1      (pc_plus1),
    .fetch_count   (fetch_count),
    .halted        (halted),
    .fetch_fault   (fetch_fault)
  );

  // Clock: 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction memory model: word i holds 0xA0+i; out-of-bounds reads return a marker.
  always_comb begin
    if (imem_addr >= 0 && imem_addr < 5) begin
      imem_rd = 32'hA0 + 32'(imem_addr);
    end else begin
      imem_rd = 32'hDEAD_BEEF;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run = tests_run + 1;
    if (got !== exp) begin
      tests_failed = tests_failed + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One clock edge, then settle; the address must never be negative.
  task automatic tick();
    @(posedge clk);
    #1;
    check_eq("addr_nonneg", {31'd0, imem_addr[31]}, 32'd0);
  endtask

  task automatic idle_inputs();
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'sd0;
    jump          = 1'b0;
    jump_target   = 32'sd0;
    halt_req      = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    idle_inputs();
    reset_n = 1'b0;

    // Reset state
    tick();
    check_eq("rst_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("rst_count", fetch_count, 32'd0);
    check_eq("rst_halted", {31'd0, halted}, 32'd0);
    check_eq("rst_fault", {31'd0, fetch_fault}, 32'd0);
    check_eq("rst_addr", imem_addr, 32'd0);
    check_eq("rst_instr", instr, 32'd0);
    check_eq("rst_instr_pc", instr_pc, 32'd0);
    check_eq("rst_pc_plus1", pc_plus1, 32'd1);
    reset_n = 1'b1;

    // Five free-running fetches
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("seq_instr", instr, 32'hA0 + 32'(i));
      check_eq("seq_instr_pc", instr_pc, 32'(i));
      check_eq("seq_valid", {31'd0, instr_valid}, 32'd1);
    end
    check_eq("seq_count", fetch_count, 32'd5);

    // PC=5 is out of range: fault on the next sequential cycle
    tick();
    check_eq("oor_fault", {31'd0, fetch_fault}, 32'd1);
    check_eq("oor_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("oor_addr", imem_addr, 32'd0);
    check_eq("oor_count", fetch_count, 32'd5);

    // FAULT is sticky with inputs toggling
    for (int i = 0; i < 10; i++) begin
      stall        = i[0];
      jump         = i[1];
      jump_target  = 32'sd2;
      branch_taken = ~i[0];
      halt_req     = i[2];
      tick();
      check_eq("flt_sticky", {31'd0, fetch_fault}, 32'd1);
      check_eq("flt_halted", {31'd0, halted}, 32'd0);
      check_eq("flt_valid", {31'd0, instr_valid}, 32'd0);
      check_eq("flt_count", fetch_count, 32'd5);
      check_eq("flt_instr_pc", instr_pc, 32'd4);
    end
    idle_inputs();

    // Stall three cycles at PC=2
    do_reset();
    tick();
    tick();
    check_eq("stl_pre_addr", imem_addr, 32'd2);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("stl_addr", imem_addr, 32'd2);
      check_eq("stl_instr", instr, 32'hA1);
      check_eq("stl_instr_pc", instr_pc, 32'd1);
      check_eq("stl_count", fetch_count, 32'd2);
      check_eq("stl_valid", {31'd0, instr_valid}, 32'd1);
    end
    stall = 1'b0;
    tick();
    check_eq("stl_rel_pc", instr_pc, 32'd2);
    check_eq("stl_rel_instr", instr, 32'hA2);
    check_eq("stl_rel_count", fetch_count, 32'd3);

    // Jump beats branch (and stall) at PC=1
    do_reset();
    tick();
    check_eq("jmp_pre_addr", imem_addr, 32'd1);
    jump          = 1'b1;
    jump_target   = 32'sd4;
    branch_taken  = 1'b1;
    branch_target = 32'sd1;
    stall         = 1'b1;
    tick();
    idle_inputs();
    check_eq("jmp_addr", imem_addr, 32'd4);
    check_eq("jmp_bubble", {31'd0, instr_valid}, 32'd0);
    check_eq("jmp_count", fetch_count, 32'd1);
    tick();
    check_eq("jmp_instr_pc", instr_pc, 32'd4);
    check_eq("jmp_instr", instr, 32'hA4);
    check_eq("jmp_valid", {31'd0, instr_valid}, 32'd1);
    check_eq("jmp_count2", fetch_count, 32'd2);

    // Halt at PC=3, then reset releases it
    do_reset();
    tick();
    tick();
    tick();
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    check_eq("hlt_halted", {31'd0, halted}, 32'd1);
    check_eq("hlt_addr", imem_addr, 32'd3);
    check_eq("hlt_valid", {31'd0, instr_valid}, 32'd0);
    tick();
    tick();
    check_eq("hlt_sticky", {31'd0, halted}, 32'd1);
    check_eq("hlt_hold_addr", imem_addr, 32'd3);
    check_eq("hlt_count", fetch_count, 32'd3);
    do_reset();
    check_eq("hlt_rst_addr", imem_addr, 32'd0);
    check_eq("hlt_rst_halted", {31'd0, halted}, 32'd0);

    // Branch to -1: accepted, one bubble, then fault
    branch_taken  = 1'b1;
    branch_target = -32'sd1;
    tick();
    idle_inputs();
    check_eq("neg_bubble", {31'd0, instr_valid}, 32'd0);
    check_eq("neg_no_fault_yet", {31'd0, fetch_fault}, 32'd0);
    check_eq("neg_addr", imem_addr, 32'd0);
    check_eq("neg_pc_plus1", pc_plus1, 32'd0);
    tick();
    check_eq("neg_fault", {31'd0, fetch_fault}, 32'd1);
    check_eq("neg_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("neg_count", fetch_count, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
